// File: rtl/gmii_rx_nibble_pack.sv
// GMII receive packer: strips the preamble and packs 4-bit (10/100) or 8-bit (1000) units into bytes.
// Optional in-band RGMII status decode is built only when RGMII_INBAND_STATUS_EN is defined.
module gmii_rx_nibble_pack (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] gmii_rxd,
   input  logic       gmii_rx_dv,
   input  logic       gmii_rx_er,
   input  logic [1:0] speed,
   output logic [7:0] out_data,
   output logic       out_valid,
   output logic       out_err,
   output logic       out_last,
   output logic       drop_pulse,
   output logic       link_up,
   output logic [1:0] link_speed,
   output logic       full_duplex
);

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_HUNT = 3'd1,
      ST_LOW  = 3'd2,
      ST_HIGH = 3'd3,
      ST_DROP = 3'd4
   } state_t;

   state_t     r_state;
   logic       r_gig;
   logic [4:0] r_hunt_cnt;
   logic [7:0] r_pend_data;
   logic       r_pend_err;
   logic [3:0] r_low_nib;
   logic       r_low_err;
   logic       r_odd;
   logic       r_dv_prev;
   logic [7:0] r_out_data;
   logic       r_out_valid;
   logic       r_out_err;
   logic       r_out_last;
   logic       r_drop_pulse;

   logic       w_gig;
   logic       w_is_pre;
   logic       w_is_sfd;
   logic [4:0] w_hunt_base;
   logic       w_hunt_go;

   // Unit classification; in IDLE the live speed applies because it is latched on that same edge
   always_comb begin
      w_gig = (r_state == ST_IDLE) ? speed[1] : r_gig;
      if (w_gig) begin
         w_is_pre = (gmii_rxd == 8'h55);
         w_is_sfd = (gmii_rxd == 8'hD5);
      end else begin
         w_is_pre = (gmii_rxd[3:0] == 4'h5);
         w_is_sfd = (gmii_rxd[3:0] == 4'hD);
      end
      w_hunt_base = (r_state == ST_IDLE) ? 5'd0 : r_hunt_cnt;
      // r_dv_prev resets high so a frame already in progress at reset release is ignored
      w_hunt_go   = gmii_rx_dv && ((r_state == ST_HUNT) || ((r_state == ST_IDLE) && !r_dv_prev));
   end

   // Frame FSM: preamble hunt, unit packing and the one-deep pending byte stage
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= ST_IDLE;
         r_gig        <= 1'b0;
         r_hunt_cnt   <= 5'd0;
         r_pend_data  <= 8'h00;
         r_pend_err   <= 1'b0;
         r_low_nib    <= 4'h0;
         r_low_err    <= 1'b0;
         r_odd        <= 1'b0;
         r_dv_prev    <= 1'b1;
         r_out_data   <= 8'h00;
         r_out_valid  <= 1'b0;
         r_out_err    <= 1'b0;
         r_out_last   <= 1'b0;
         r_drop_pulse <= 1'b0;
      end else begin
         r_dv_prev    <= gmii_rx_dv;
         r_out_valid  <= 1'b0;
         r_out_err    <= 1'b0;
         r_out_last   <= 1'b0;
         r_drop_pulse <= 1'b0;
         case (r_state)
            ST_IDLE, ST_HUNT: begin
               if (r_odd) begin
                  r_out_valid <= 1'b1;
                  r_out_data  <= {4'h0, r_low_nib};
                  r_out_err   <= 1'b1;
                  r_out_last  <= 1'b1;
                  r_odd       <= 1'b0;
               end
               if (w_hunt_go) begin
                  r_gig <= w_gig;
                  if (gmii_rx_er || !(w_is_pre || w_is_sfd) || (w_is_pre && (w_hunt_base == 5'd23))) begin
                     r_state      <= ST_DROP;
                     r_drop_pulse <= 1'b1;
                     r_hunt_cnt   <= 5'd0;
                  end else if (w_is_sfd) begin
                     r_state     <= ST_LOW;
                     r_pend_data <= 8'hD5;
                     r_pend_err  <= 1'b0;
                     r_hunt_cnt  <= 5'd0;
                  end else begin
                     r_state    <= ST_HUNT;
                     r_hunt_cnt <= w_hunt_base + 5'd1;
                  end
               end else if (r_state == ST_HUNT) begin
                  r_state      <= ST_IDLE;
                  r_drop_pulse <= 1'b1;
                  r_hunt_cnt   <= 5'd0;
               end
            end
            ST_LOW: begin
               if (gmii_rx_dv && r_gig) begin
                  r_out_valid <= 1'b1;
                  r_out_data  <= r_pend_data;
                  r_out_err   <= r_pend_err;
                  r_pend_data <= gmii_rxd;
                  r_pend_err  <= gmii_rx_er;
               end else if (gmii_rx_dv) begin
                  r_low_nib <= gmii_rxd[3:0];
                  r_low_err <= gmii_rx_er;
                  r_state   <= ST_HIGH;
               end else begin
                  r_out_valid <= 1'b1;
                  r_out_data  <= r_pend_data;
                  r_out_err   <= r_pend_err;
                  r_out_last  <= 1'b1;
                  r_state     <= ST_IDLE;
               end
            end
            ST_HIGH: begin
               r_out_valid <= 1'b1;
               r_out_data  <= r_pend_data;
               r_out_err   <= r_pend_err;
               if (gmii_rx_dv) begin
                  r_pend_data <= {gmii_rxd[3:0], r_low_nib};
                  r_pend_err  <= r_low_err | gmii_rx_er;
                  r_state     <= ST_LOW;
               end else begin
                  // Trailing lone nibble goes out next cycle from IDLE as an errored last byte
                  r_odd   <= 1'b1;
                  r_state <= ST_IDLE;
               end
            end
            ST_DROP: begin
               if (!gmii_rx_dv) begin
                  r_state <= ST_IDLE;
               end
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign out_data   = r_out_data;
   assign out_valid  = r_out_valid;
   assign out_err    = r_out_err;
   assign out_last   = r_out_last;
   assign drop_pulse = r_drop_pulse;

`ifdef RGMII_INBAND_STATUS_EN
   logic [3:0] r_ib_prev;
   logic       r_ib_vld;
   logic       r_link_up;
   logic [1:0] r_link_speed;
   logic       r_full_duplex;

   // In-band status: accept a nibble only when it repeats on two consecutive IFG cycles
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ib_prev     <= 4'h0;
         r_ib_vld      <= 1'b0;
         r_link_up     <= 1'b0;
         r_link_speed  <= 2'b00;
         r_full_duplex <= 1'b0;
      end else if (!gmii_rx_dv && !gmii_rx_er) begin
         r_ib_prev <= gmii_rxd[3:0];
         r_ib_vld  <= 1'b1;
         if (r_ib_vld && (gmii_rxd[3:0] == r_ib_prev)) begin
            r_link_up     <= gmii_rxd[0];
            r_link_speed  <= gmii_rxd[2:1];
            r_full_duplex <= gmii_rxd[3];
         end
      end else begin
         r_ib_vld <= 1'b0;
      end
   end

   assign link_up     = r_link_up;
   assign link_speed  = r_link_speed;
   assign full_duplex = r_full_duplex;
`else
   assign link_up     = 1'b0;
   assign link_speed  = 2'b00;
   assign full_duplex = 1'b0;
`endif

endmodule

// File: tb/tb_gmii_rx_nibble_pack.sv
// Scoreboard bench for gmii_rx_nibble_pack: a frame-level reference model queues expected bytes,
// an independent monitor pops and compares whenever out_valid is seen.
module tb_gmii_rx_nibble_pack;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] gmii_rxd;
   logic       gmii_rx_dv;
   logic       gmii_rx_er;
   logic [1:0] speed;
   logic [7:0] out_data;
   logic       out_valid;
   logic       out_err;
   logic       out_last;
   logic       drop_pulse;
   logic       link_up;
   logic [1:0] link_speed;
   logic       full_duplex;

   gmii_rx_nibble_pack dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .gmii_rxd    (gmii_rxd),
      .gmii_rx_dv  (gmii_rx_dv),
      .gmii_rx_er  (gmii_rx_er),
      .speed       (speed),
      .out_data    (out_data),
      .out_valid   (out_valid),
      .out_err     (out_err),
      .out_last    (out_last),
      .drop_pulse  (drop_pulse),
      .link_up     (link_up),
      .link_speed  (link_speed),
      .full_duplex (full_duplex)
   );

   always #5 clk = ~clk;

   logic [9:0] exp_q[$];    // {data, err, last}
   logic [9:0] mon_exp;
   logic [7:0] u_q[$];
   logic       e_q[$];
   int         checks = 0;
   int         errors = 0;
   int         exp_drops = 0;
   int         obs_drops = 0;

   // Monitor: every emitted byte must match the head of the expectation queue
   always @(negedge clk) begin
      if (rst_n) begin
         if (out_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_byte: got data=%02h err=%0b last=%0b, none expected",
                        out_data, out_err, out_last);
            end else begin
               mon_exp = exp_q.pop_front();
               if ({out_data, out_err, out_last} !== mon_exp) begin
                  errors++;
                  $display("FAIL byte: got data=%02h err=%0b last=%0b, want data=%02h err=%0b last=%0b",
                           out_data, out_err, out_last, mon_exp[9:2], mon_exp[1], mon_exp[0]);
               end
            end
         end
         if (drop_pulse) obs_drops++;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %0h, want %0h", nm, got, want);
      end
   endtask

   task automatic push_u(input logic [7:0] v, input logic e);
      u_q.push_back(v);
      e_q.push_back(e);
   endtask

   // Reference model: applies the hunt/pack rules to a whole frame of units
   task automatic model_frame(input logic gig);
      logic [9:0] res[$];
      int         cnt;
      int         i;
      int         j;
      int         n;
      bit         go;
      bit         pre;
      bit         sfd;
      cnt = 0; i = 0; go = 0; n = u_q.size();
      while (i < n) begin
         pre = gig ? (u_q[i] == 8'h55) : (u_q[i][3:0] == 4'h5);
         sfd = gig ? (u_q[i] == 8'hD5) : (u_q[i][3:0] == 4'hD);
         if (e_q[i] || !(pre || sfd)) break;
         i++;
         if (sfd) begin
            go = 1;
            break;
         end
         cnt++;
         if (cnt == 24) break;
      end
      if (!go) begin
         exp_drops++;
         return;
      end
      res.push_back({8'hD5, 1'b0, 1'b0});
      if (gig) begin
         for (j = i; j < n; j++) res.push_back({u_q[j], e_q[j], 1'b0});
      end else begin
         j = i;
         while (j + 1 < n) begin
            res.push_back({u_q[j+1][3:0], u_q[j][3:0], e_q[j] | e_q[j+1], 1'b0});
            j += 2;
         end
         if (j < n) res.push_back({4'h0, u_q[j][3:0], 1'b1, 1'b0});
      end
      res[res.size()-1][0] = 1'b1;
      foreach (res[k]) exp_q.push_back(res[k]);
   endtask

   task automatic drive_frame(input bit chg);
      for (int i = 0; i < u_q.size(); i++) begin
         gmii_rx_dv = 1'b1;
         gmii_rx_er = e_q[i];
         gmii_rxd   = u_q[i];
         tick();
         if (chg) speed = 2'($urandom);
      end
      gmii_rx_dv = 1'b0;
      gmii_rx_er = 1'b0;
      gmii_rxd   = 8'($urandom);
      repeat ($urandom_range(1, 3)) tick();
   endtask

   task automatic run_frame(input logic [1:0] spd, input bit chg);
      speed = spd;
      model_frame(spd[1]);
      drive_frame(chg);
   endtask

   function automatic logic [7:0] mk(input logic gig, input logic [3:0] nib, input logic [7:0] byt);
      logic [7:0] r;
      r = 8'($urandom);
      if (gig) r = byt;
      else r[3:0] = nib;
      return r;
   endfunction

   function automatic logic [7:0] bad_unit(input logic gig);
      logic [7:0] v;
      v = 8'($urandom);
      while (gig ? (v == 8'h55 || v == 8'hD5) : (v[3:0] == 4'h5 || v[3:0] == 4'hD)) v = 8'($urandom);
      return v;
   endfunction

   // kind 0: good, 1: illegal unit, 2: rx_er in hunt, 3: preamble too long
   task automatic gen_frame(input logic gig, input int kind);
      int npre;
      int nd;
      u_q.delete();
      e_q.delete();
      case (kind)
         0:       npre = ($urandom_range(0, 7) == 0) ? 23 : $urandom_range(0, 10);
         3:       npre = $urandom_range(24, 26);
         default: npre = $urandom_range(0, 6);
      endcase
      for (int i = 0; i < npre; i++) push_u(mk(gig, 4'h5, 8'h55), 1'b0);
      if (kind == 1) begin
         push_u(bad_unit(gig), 1'b0);
         nd = $urandom_range(0, 3);
         for (int i = 0; i < nd; i++) push_u(8'($urandom), 1'($urandom));
      end else begin
         if (kind == 2) push_u(mk(gig, 4'h5, 8'h55), 1'b1);
         push_u(mk(gig, 4'hD, 8'hD5), 1'b0);
         nd = $urandom_range(0, 12);
         for (int i = 0; i < nd; i++) push_u(8'($urandom), ($urandom_range(0, 7) == 0));
      end
   endtask

   task automatic drain();
      int k;
      k = 0;
      while (exp_q.size() != 0 && k < 200) begin
         tick();
         k++;
      end
      chk("drain_queue_empty", exp_q.size(), 0);
      repeat (3) tick();
   endtask

   initial begin
      logic [1:0] spd;
      rst_n      = 1'b0;
      gmii_rxd   = 8'h00;
      gmii_rx_dv = 1'b0;
      gmii_rx_er = 1'b0;
      speed      = 2'b00;
      repeat (3) tick();
      chk("reset_out_valid", out_valid, 0);
      chk("reset_out_data", out_data, 0);
      chk("reset_out_last", out_last, 0);
      chk("reset_drop_pulse", drop_pulse, 0);
      chk("reset_link_up", link_up, 0);
      rst_n = 1'b1;
      repeat (2) tick();

`ifdef RGMII_INBAND_STATUS_EN
      gmii_rxd = 8'h00; tick(); tick();
      gmii_rxd = 8'h0D; tick();
      gmii_rxd = 8'h01; tick();
      chk("ib_single_link_up", link_up, 0);
      chk("ib_single_speed", link_speed, 0);
      gmii_rxd = 8'h0D; tick(); tick();
      chk("ib_link_up", link_up, 1);
      chk("ib_link_speed", link_speed, 2);
      chk("ib_full_duplex", full_duplex, 1);
`endif

      // 100M reference frame
      u_q.delete(); e_q.delete();
      for (int i = 0; i < 15; i++) push_u(8'h05, 1'b0);
      push_u(8'h0D, 1'b0);
      for (int i = 1; i <= 4; i++) push_u(8'(i), 1'b0);
      run_frame(2'b01, 1'b1);

      // 1000M frame with error on the last byte
      u_q.delete(); e_q.delete();
      for (int i = 0; i < 7; i++) push_u(8'h55, 1'b0);
      push_u(8'hD5, 1'b0);
      push_u(8'hAA, 1'b0);
      push_u(8'hBB, 1'b1);
      run_frame(2'b10, 1'b1);

      // 10M drop then a good frame
      u_q.delete(); e_q.delete();
      push_u(8'h05, 1'b0);
      push_u(8'h03, 1'b0);
      run_frame(2'b00, 1'b0);
      u_q.delete(); e_q.delete();
      push_u(8'h05, 1'b0);
      push_u(8'h0D, 1'b0);
      push_u(8'h09, 1'b0);
      push_u(8'h0C, 1'b0);
      run_frame(2'b00, 1'b0);

      // 100M odd nibble, SFD as first unit
      u_q.delete(); e_q.delete();
      push_u(8'h0D, 1'b0);
      push_u(8'h06, 1'b0);
      push_u(8'h07, 1'b0);
      push_u(8'h08, 1'b0);
      run_frame(2'b01, 1'b0);

      for (int f = 0; f < 250; f++) begin
         spd = 2'($urandom);
         gen_frame(spd[1], ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0);
         run_frame(spd, ($urandom_range(0, 1) == 1));
      end
      drain();

      // Reset mid-frame: partial frame vanishes, a later frame is intact
      speed = 2'b01;
      for (int i = 0; i < 7; i++) begin
         gmii_rx_dv = 1'b1; gmii_rxd = 8'h05; tick();
      end
      gmii_rxd = 8'h0D; tick();
      gmii_rxd = 8'h03; tick();
      rst_n = 1'b0;
      #1;
      chk("midrst_out_valid", out_valid, 0);
      chk("midrst_out_data", out_data, 0);
      chk("midrst_out_err", out_err, 0);
      chk("midrst_out_last", out_last, 0);
      chk("midrst_drop_pulse", drop_pulse, 0);
      tick(); tick();
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         gmii_rxd = 8'h03; tick();
      end
      gmii_rx_dv = 1'b0; tick();
      u_q.delete(); e_q.delete();
      for (int i = 0; i < 7; i++) push_u(8'h05, 1'b0);
      push_u(8'h0D, 1'b0);
      for (int i = 0; i < 6; i++) push_u(8'($urandom), 1'b0);
      run_frame(2'b01, 1'b0);
      drain();

      chk("drop_pulse_count", obs_drops, exp_drops);
`ifndef RGMII_INBAND_STATUS_EN
      chk("status_link_up_off", link_up, 0);
      chk("status_speed_off", link_speed, 0);
      chk("status_duplex_off", full_duplex, 0);
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
